// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared types for the calculator sequencer: operation codes,
//            FSM state codes and the operation-key priority encoder.
// Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_B     = 3'd1,
        S_OP    = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_SHOW  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // Simultaneous key presses resolve add > sub > mult > div; callers qualify
    // the result with the OR of all four pulses.
    function automatic op_t op_encode(input logic add_p, input logic sub_p,
                                      input logic mul_p, input logic div_p);
        op_t code;
        if (add_p)      code = OP_ADD;
        else if (sub_p) code = OP_SUB;
        else if (mul_p) code = OP_MUL;
        else if (div_p) code = OP_DIV;
        else            code = OP_DIV;
        return code;
    endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/key_pulse.sv
`default_nettype none
// ============================================================================
// Module   : key_pulse
// Purpose  : Synchronises one asynchronous active-low key and emits a single
//            registered one-cycle pulse per press (SYNC+1 cycles latency).
// Revision : 1.0  initial release
// ============================================================================
module key_pulse #(
    parameter int SYNC = 2
) (
    input  logic clock,
    input  logic clear,
    input  logic key_n,
    output logic pulse
);

    logic [SYNC-1:0] sync_q, sync_d;
    logic            last_q, last_d;
    logic            pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[SYNC-2:0], key_n};
        last_d  = sync_q[SYNC-1];
        pulse_d = last_q & ~sync_q[SYNC-1];
    end

    // Idle keys are high, so the chain resets to ones to avoid a false press.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync_q  <= '1;
            last_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            last_q  <= last_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule : key_pulse
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Purpose  : Control sequencer for the four-function calculator: latches
//            operands and operation, starts the datapath, waits for done with
//            a timeout, traps divide-by-zero. Define CALC_CHAIN_EN to allow
//            chaining the displayed result into the next operation.
// Revision : 1.0  initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SYNC    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enter_n,
    input  logic             add_n,
    input  logic             sub_n,
    input  logic             mult_n,
    input  logic             div_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] result_in,
    input  logic             done,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    output logic [1:0]       op,
    output logic             start,
    output logic             load_r,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state_o
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic enter_p, add_p, sub_p, mul_p, div_p;
    logic op_any;
    op_t  op_code;

    key_pulse #(.SYNC(SYNC)) u_key_enter (.clock(clock), .clear(clear), .key_n(enter_n), .pulse(enter_p));
    key_pulse #(.SYNC(SYNC)) u_key_add   (.clock(clock), .clear(clear), .key_n(add_n),   .pulse(add_p));
    key_pulse #(.SYNC(SYNC)) u_key_sub   (.clock(clock), .clear(clear), .key_n(sub_n),   .pulse(sub_p));
    key_pulse #(.SYNC(SYNC)) u_key_mult  (.clock(clock), .clear(clear), .key_n(mult_n),  .pulse(mul_p));
    key_pulse #(.SYNC(SYNC)) u_key_div   (.clock(clock), .clear(clear), .key_n(div_n),   .pulse(div_p));

    assign op_any  = add_p | sub_p | mul_p | div_p;
    assign op_code = op_encode(add_p, sub_p, mul_p, div_p);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    op_t              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;

`ifndef CALC_CHAIN_EN
    logic unused_result;
    assign unused_result = ^result_in;
`endif

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;

        case (state_q)
            S_A: begin
                if (enter_p) begin
                    opa_d   = data_in;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (enter_p) begin
                    opb_d   = data_in;
                    state_d = S_OP;
`ifdef CALC_CHAIN_EN
                    // A chained operation already has its op, so skip S_OP.
                    if (pend_q) begin
                        state_d = (op_q == OP_DIV && data_in == '0) ? S_ERR : S_START;
                    end
`endif
                end
            end
            S_OP: begin
                if (op_any) begin
                    op_d    = op_code;
                    state_d = (op_code == OP_DIV && opb_q == '0) ? S_ERR : S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                pend_d  = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    state_d = S_SHOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHOW: begin
                if (enter_p) begin
                    state_d = S_A;
                end
`ifdef CALC_CHAIN_EN
                else if (op_any) begin
                    opa_d   = result_in;
                    op_d    = op_code;
                    pend_d  = 1'b1;
                    state_d = S_B;
                end
`endif
            end
            S_ERR: begin
                pend_d = 1'b0;
                if (enter_p) begin
                    state_d = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_A;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign opa     = opa_q;
    assign opb     = opb_q;
    assign op      = op_q;
    assign start   = (state_q == S_START);
    assign load_r  = (state_q == S_WAIT) && done;
    assign busy    = (state_q == S_START) || (state_q == S_WAIT);
    assign err     = (state_q == S_ERR);
    assign state_o = state_q;

endmodule : calc_sequencer
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Purpose  : Scoreboard bench for calc_sequencer; stimulus queues expected
//            start/load/error events, a monitor pops and compares them.
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int WIDTH   = 8;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 64;

    localparam int EV_START = 0;
    localparam int EV_LOAD  = 1;
    localparam int EV_ERR   = 2;

    logic             clock = 1'b0;
    logic             clear = 1'b0;
    logic [4:0]       keys_n = 5'b11111;   // {div, mult, sub, add, enter}
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] result_in = '0;
    logic             done = 1'b0;
    logic [WIDTH-1:0] opa, opb;
    logic [1:0]       op;
    logic             start, load_r, busy, err;
    logic [2:0]       state_o;

    calc_sequencer #(.WIDTH(WIDTH), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .clear    (clear),
        .enter_n  (keys_n[0]),
        .add_n    (keys_n[1]),
        .sub_n    (keys_n[2]),
        .mult_n   (keys_n[3]),
        .div_n    (keys_n[4]),
        .data_in  (data_in),
        .result_in(result_in),
        .done     (done),
        .opa      (opa),
        .opb      (opb),
        .op       (op),
        .start    (start),
        .load_r   (load_r),
        .busy     (busy),
        .err      (err),
        .state_o  (state_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] o;
        int         dly;   // cycles after start, -1 = not checked
    } exp_t;

    exp_t sbq[$];

    function automatic void exp_start(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        exp_t e;
        e.kind = EV_START; e.a = a; e.b = b; e.o = o; e.dly = -1;
        sbq.push_back(e);
    endfunction

    function automatic void exp_event(input int kind, input int dly);
        exp_t e;
        e.kind = kind; e.a = '0; e.b = '0; e.o = '0; e.dly = dly;
        sbq.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    int   last_start = 0;
    logic err_prev = 1'b0;

    task automatic on_event(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = sbq.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == EV_START) begin
                last_start = cyc;
                if (e.kind == EV_START) begin
                    check("start_opa", {24'b0, opa}, {24'b0, e.a});
                    check("start_opb", {24'b0, opb}, {24'b0, e.b});
                    check("start_op",  {30'b0, op},  {30'b0, e.o});
                end
            end else if (kind == e.kind && e.dly >= 0) begin
                check("event_delay", cyc - last_start, e.dly);
            end
        end
    endtask

    always @(negedge clock) begin
        if (clear !== 1'b1) begin
            err_prev = 1'b0;
        end else begin
            if (start !== 1'b0)  on_event(EV_START);
            if (load_r !== 1'b0) on_event(EV_LOAD);
            if (err !== 1'b0 && err_prev == 1'b0) on_event(EV_ERR);
            err_prev = err;
        end
    end

    // ---------------- datapath model (sole driver of done) ----------------
    int done_delay = -1;
    int kick_req = 0;
    int kick_ack = 0;

    initial forever begin
        @(negedge clock);
        if (start === 1'b1 && done_delay >= 0) begin
            repeat (done_delay) @(posedge clock);
            #1 done = 1'b1;
            @(posedge clock);
            #1 done = 1'b0;
        end else if (kick_req != kick_ack) begin
            kick_ack = kick_req;
            @(posedge clock);
            #1 done = 1'b1;
            @(posedge clock);
            #1 done = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [4:0] mask, input int hold);
        @(posedge clock);
        #1 keys_n = ~mask;
        repeat (hold) @(posedge clock);
        #1 keys_n = 5'b11111;
        repeat (SYNC + 3) @(posedge clock);
        #1;
    endtask

    task automatic enter_val(input logic [7:0] v);
        data_in = v;
        press(5'b00001, 2);
    endtask

    task automatic check_state(input string name, input logic [2:0] expv);
        @(negedge clock);
        check(name, {29'b0, state_o}, {29'b0, expv});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        idle(3);
        @(negedge clock);
        check("reset_state", {29'b0, state_o}, 32'd0);
        check("reset_ops", {14'b0, opa, opb, op}, 32'd0);
        check("reset_ctrl", {28'b0, start, load_r, busy, err}, 32'd0);
        @(posedge clock);
        #1 clear = 1'b1;
        idle(2);

        // 1: 0x12 + 0x05, done three cycles after start
        done_delay = 3;
        exp_start(8'h12, 8'h05, 2'b00);
        exp_event(EV_LOAD, 3);
        enter_val(8'h12);
        enter_val(8'h05);
        press(5'b00010, 2);
        idle(10);
        check_state("t1_show", 3'd5);
        press(5'b00001, 2);
        check_state("t1_back_to_a", 3'd0);

        // 2: divide by zero traps without start
        exp_event(EV_ERR, -1);
        enter_val(8'h40);
        enter_val(8'h00);
        press(5'b10000, 2);
        idle(3);
        check_state("t2_err_state", 3'd6);
        check("t2_err_flag", {31'b0, err}, 32'd1);
        press(5'b00001, 2);
        check_state("t2_recover", 3'd0);
        check("t2_err_clear", {31'b0, err}, 32'd0);

        // 3: timeout; S_WAIT holds TIMEOUT cycles (count 0..TIMEOUT-1) after start
        done_delay = -1;
        exp_start(8'h21, 8'h03, 2'b10);
        exp_event(EV_ERR, TIMEOUT + 1);
        enter_val(8'h21);
        enter_val(8'h03);
        press(5'b01000, 2);
        idle(TIMEOUT + 10);
        check_state("t3_timeout_state", 3'd6);
        kick_req++;
        idle(5);
        check_state("t3_late_done_state", 3'd6);
        press(5'b00001, 2);
        check_state("t3_recover", 3'd0);

        // 4: held enter latches once; add beats div; done in S_SHOW ignored
        done_delay = 2;
        data_in = 8'h33;
        @(posedge clock);
        #1 keys_n[0] = 1'b0;
        idle(8);
        data_in = 8'h55;
        idle(8);
        check_state("t4_held_enter_state", 3'd1);
        check("t4_held_enter_opa", {24'b0, opa}, 32'h33);
        keys_n[0] = 1'b1;
        idle(SYNC + 3);
        exp_start(8'h33, 8'h0A, 2'b00);
        exp_event(EV_LOAD, 2);
        enter_val(8'h0A);
        press(5'b10010, 2);
        idle(12);
        check_state("t4_show", 3'd5);
        kick_req++;
        idle(5);
        check_state("t4_done_in_show", 3'd5);
        press(5'b00001, 2);
        check_state("t4_back_to_a", 3'd0);

        // 5: clear during S_WAIT drops the in-flight done
        done_delay = 8;
        exp_start(8'h66, 8'h77, 2'b01);
        enter_val(8'h66);
        enter_val(8'h77);
        press(5'b00100, 2);
        check("t5_busy_before_clear", {31'b0, busy}, 32'd1);
        clear = 1'b0;
        idle(2);
        clear = 1'b1;
        idle(15);
        check_state("t5_state", 3'd0);
        check("t5_ops", {14'b0, opa, opb, op}, 32'd0);
        check("t5_ctrl", {28'b0, start, load_r, busy, err}, 32'd0);

        // 6: chaining from S_SHOW
        done_delay = 2;
        exp_start(8'h11, 8'h22, 2'b00);
        exp_event(EV_LOAD, 2);
        enter_val(8'h11);
        enter_val(8'h22);
        press(5'b00010, 2);
        idle(12);
        check_state("t6_show", 3'd5);
        result_in = 8'h17;
`ifdef CALC_CHAIN_EN
        exp_start(8'h17, 8'h07, 2'b01);
        exp_event(EV_LOAD, 2);
        press(5'b00100, 2);
        check_state("t6_chain_b", 3'd1);
        enter_val(8'h07);
        idle(12);
        check_state("t6_chain_show", 3'd5);
`else
        press(5'b00100, 2);
        idle(4);
        check_state("t6_no_chain_state", 3'd5);
        check("t6_no_chain_opa", {24'b0, opa}, 32'h11);
`endif
        press(5'b00001, 2);
        check_state("t6_back_to_a", 3'd0);

        // Every queued expectation must have been consumed
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clock);
        check("scoreboard_drained", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_calc_sequencer
`default_nettype wire
